// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability-counting debounce FSM,
// registered level plus one-clock press/release pulses.
// Optional auto-repeat of press_pulse while held: define DEBOUNCE_REPEAT_EN.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter bit          ACTIVE_LOW      = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 25_000_000,
  parameter int unsigned REP_WIDTH       = 26
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  // Counter value seen on the DEBOUNCE_CYCLES-th consecutive stable sample.
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_cnt
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and < 2**CNT_WIDTH");
  end

  logic [1:0]           sync_q;
  logic                 btn_sync;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 level_d, press_d, release_d;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [REP_WIDTH-1:0] RepDelay  = REP_WIDTH'(REPEAT_DELAY);
  localparam logic [REP_WIDTH-1:0] RepPeriod = REP_WIDTH'(REPEAT_PERIOD);

  if (REPEAT_PERIOD < 2 || REPEAT_DELAY < 2 ||
      64'(REPEAT_DELAY) >= (64'd1 << REP_WIDTH) ||
      64'(REPEAT_PERIOD) >= (64'd1 << REP_WIDTH)) begin : g_bad_rep
    $error("button_debounce: repeat timing must be >= 2 and fit REP_WIDTH");
  end

  logic [REP_WIDTH-1:0] rep_q, rep_d, rep_inc;
  logic                 rep_first_q, rep_first_d;

  assign rep_inc = rep_q + 1'b1;
`endif

  assign btn_sync = sync_q[1];
  assign cnt_inc  = cnt_q + 1'b1;

  // Synchroniser on the polarity-normalised pin; idle value is "not pressed".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_in ^ ACTIVE_LOW};
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    // Repeat timing only survives while we stay in StPressed.
    rep_d       = '0;
    rep_first_d = 1'b1;
`endif
    unique case (state_q)
      StReleased: begin
        if (btn_sync) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_sync) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d = StPressed;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressed: begin
        if (!btn_sync) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else begin
`ifdef DEBOUNCE_REPEAT_EN
          if (rep_inc == (rep_first_q ? RepDelay : RepPeriod)) begin
            press_d     = 1'b1;
            rep_d       = '0;
            rep_first_d = 1'b0;
          end else begin
            rep_d       = rep_inc;
            rep_first_d = rep_first_q;
          end
`endif
        end
      end
      StReleaseWait: begin
        if (btn_sync) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d   = StReleased;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == StPressed) || (state_d == StReleaseWait);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StReleased;
      cnt_q         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  // Auto-repeat timer, active only while held in StPressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4 (REPEAT_DELAY=10,
// REPEAT_PERIOD=5 when DEBOUNCE_REPEAT_EN is defined).
module tb_button_debounce;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       btn;
    logic [2:0] exp;  // {btn_level, press_pulse, release_pulse}
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3),
    .ACTIVE_LOW     (1'b0)
`ifdef DEBOUNCE_REPEAT_EN
    ,
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .REP_WIDTH      (5)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  function automatic logic [2:0] outs();
    return {btn_level, press_pulse, release_pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {level,press,release}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic b, input logic l, input logic p, input logic r, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{btn: b, exp: {l, p, r}});
  endtask

  initial begin
    // Clean press held 20 clks, release, short glitch, then a bouncing press.
    add(1'b1, 1'b0, 1'b0, 1'b0, 5);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1);
    if (RepEn) begin
      add(1'b1, 1'b1, 1'b0, 1'b0, 9);
      add(1'b1, 1'b1, 1'b1, 1'b0, 1);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1);
    end else begin
      add(1'b1, 1'b1, 1'b0, 1'b0, 14);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1);
    end
    add(1'b0, 1'b1, 1'b0, 1'b0, 4);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(1'b1, 1'b0, 1'b0, 1'b0, 5);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 3);
    add(1'b0, 1'b1, 1'b0, 1'b0, 5);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Reset held with the button already pressed.
    reset  = 1'b1;
    btn_in = 1'b1;
    repeat (3) tick();
    check("reset_hold", outs(), 3'b000);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("post_reset_clk%0d", i), outs(), (i == 6) ? 3'b110 : 3'b000);
    end
    tick();
    check("post_reset_level", outs(), 3'b100);
    // Asynchronous assertion must clear the level without waiting for a clock.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clears", outs(), 3'b000);
    tick();
    tick();
    reset  = 1'b0;
    btn_in = 1'b0;
    repeat (4) tick();
    check("idle_after_reset", outs(), 3'b000);

    // Table vectors.
    foreach (vecs[i]) begin
      btn_in = vecs[i].btn;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset two clocks into the press debounce window.
    btn_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("pre_abort_clk%0d", i), outs(), 3'b000);
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_reset", outs(), 3'b000);
    tick();
    check("abort_reset_held", outs(), 3'b000);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("after_abort_clk%0d", i), outs(), (i == 6) ? 3'b110 : 3'b000);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("abort_release_clk%0d", i), outs(), (i == 6) ? 3'b001 : 3'b100);
    end
    repeat (4) tick();

    // Long hold: single press_pulse, or auto-repeat at +10 then every +5.
    for (int i = 0; i < 50; i++) begin
      logic exp_p, exp_l, exp_r;
      btn_in = (i < 40);
      tick();
      exp_p = (i == 5) || (RepEn && i >= 15 && i <= 40 && ((i - 15) % 5) == 0);
      exp_l = (i >= 5) && (i < 45);
      exp_r = (i == 45);
      check($sformatf("hold_clk%0d", i), outs(), {exp_l, exp_p, exp_r});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
